// File: rtl/phase_sel_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : phase_sel_gen                                            |
// | Description : LFSR-driven select generator for 7 clock phase muxes,    |
// |               with programmable idle interval and post-update guard.   |
// | Revision    : 1.0                                                      |
// +------------------------------------------------------------------------+
module phase_sel_gen #(
    parameter int          GUARD_CYCLES = 8,
    parameter logic [15:0] RESET_SEED   = 16'hACE1
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  interval,
    input  logic        seed_load,
    input  logic [15:0] seed,
    output logic [6:0]  sel,
    output logic        sel_stb,
    output logic        active
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_COUNT  = 2'd1;
    localparam logic [1:0] S_UPDATE = 2'd2;
    localparam logic [1:0] S_GUARD  = 2'd3;

    localparam logic [7:0] c_guard_init = 8'(GUARD_CYCLES - 1);

    logic [1:0]  r_state;
    logic [7:0]  r_cnt;
    logic [7:0]  r_gcnt;
    logic [15:0] r_lfsr;
    logic [6:0]  r_sel;
    logic        r_stb;

    logic [1:0]  w_state_nxt;
    logic [7:0]  w_cnt_nxt;
    logic [7:0]  w_gcnt_nxt;
    logic [15:0] w_lfsr_nxt;
    logic [6:0]  w_sel_nxt;
    logic        w_stb_nxt;
    logic        w_fb;

    assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_gcnt  <= 8'd0;
            r_lfsr  <= RESET_SEED;
            r_sel   <= 7'h00;
            r_stb   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gcnt  <= w_gcnt_nxt;
            r_lfsr  <= w_lfsr_nxt;
            r_sel   <= w_sel_nxt;
            r_stb   <= w_stb_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_gcnt_nxt  = r_gcnt;
        w_sel_nxt   = r_sel;
        w_stb_nxt   = 1'b0;

        // A seed load wins over the free-running advance; zero would lock the LFSR.
        if (seed_load) begin
            w_lfsr_nxt = (seed == 16'h0000) ? RESET_SEED : seed;
        end else if (r_state != S_IDLE) begin
            w_lfsr_nxt = {r_lfsr[14:0], w_fb};
        end else begin
            w_lfsr_nxt = r_lfsr;
        end

        case (r_state)
            S_IDLE: begin
                if (en) begin
                    w_state_nxt = S_COUNT;
                    w_cnt_nxt   = interval;
                end
            end
            S_COUNT: begin
                if (r_cnt == 8'd0) begin
                    w_state_nxt = S_UPDATE;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            S_UPDATE: begin
                w_sel_nxt   = r_lfsr[6:0];
                w_stb_nxt   = 1'b1;
                w_state_nxt = S_GUARD;
                w_gcnt_nxt  = c_guard_init;
            end
            default: begin
                // en is only honoured here, so an update in flight always finishes.
                if (r_gcnt == 8'd0) begin
                    if (en) begin
                        w_state_nxt = S_COUNT;
                        w_cnt_nxt   = interval;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_gcnt_nxt = r_gcnt - 8'd1;
                end
            end
        endcase
    end

    assign sel     = r_sel;
    assign sel_stb = r_stb;
    assign active  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_phase_sel_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_phase_sel_gen                                         |
// | Description : Directed self-checking bench for phase_sel_gen.          |
// | Revision    : 1.0                                                      |
// +------------------------------------------------------------------------+
module tb_phase_sel_gen;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  interval;
    logic        seed_load;
    logic [15:0] seed;
    logic [6:0]  sel;
    logic        sel_stb;
    logic        active;

    int checks = 0;
    int errors = 0;

    phase_sel_gen #(
        .GUARD_CYCLES(8),
        .RESET_SEED  (16'hACE1)
    ) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .en       (en),
        .interval (interval),
        .seed_load(seed_load),
        .seed     (seed),
        .sel      (sel),
        .sel_stb  (sel_stb),
        .active   (active)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [15:0] lstep(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [15:0] lstepn(input logic [15:0] v, input int n);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = lstep(r);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] m;
        logic [15:0] t;
        logic [6:0]  held;
        logic [6:0]  last_sel;
        logic        exp_stb;

        rst = 1'b1; en = 1'b0; interval = 8'd0; seed_load = 1'b0; seed = 16'h0000;
        tick();
        tick();
        chk("rst_sel", 16'(sel), 16'h0000);
        chk("rst_stb", 16'(sel_stb), 16'h0000);
        chk("rst_active", 16'(active), 16'h0000);
        rst = 1'b0;

        // Seed 0x0001, interval 0: first two selects are 0x02 then 0x01.
        seed_load = 1'b1; seed = 16'h0001;
        tick();
        seed_load = 1'b0;
        en = 1'b1; interval = 8'd0;
        tick();
        chk("r28_active_k", 16'(active), 16'h0001);
        chk("r28_stb_k", 16'(sel_stb), 16'h0000);
        tick();
        chk("r28_stb_k1", 16'(sel_stb), 16'h0000);
        tick();
        chk("r28_sel_k2", 16'(sel), 16'h0002);
        chk("r28_stb_k2", 16'(sel_stb), 16'h0001);
        for (int i = 3; i <= 11; i++) begin
            tick();
            chk($sformatf("r28_stb_gap%0d", i), 16'(sel_stb), 16'h0000);
            chk($sformatf("r28_sel_hold%0d", i), 16'(sel), 16'h0002);
        end
        tick();
        chk("r28_sel_k12", 16'(sel), 16'h0001);
        chk("r28_stb_k12", 16'(sel_stb), 16'h0001);
        en = 1'b0;
        do_reset();

        // Zero seed substitutes ACE1, whose first advance gives select 0x43.
        seed_load = 1'b1; seed = 16'h1234;
        tick();
        seed = 16'h0000;
        tick();
        seed_load = 1'b0;
        en = 1'b1; interval = 8'd0;
        tick();
        en = 1'b0;
        tick();
        tick();
        chk("r29_stb", 16'(sel_stb), 16'h0001);
        chk("r29_sel", 16'(sel), 16'h0043);
        chk("r29_sel_model", 16'(sel), 16'(lstep(16'hACE1) & 16'h007F));
        do_reset();

        // en dropped in COUNT: update finishes, guard completes, then IDLE freezes LFSR.
        en = 1'b1; interval = 8'd3;
        tick();
        en = 1'b0;
        for (int i = 1; i <= 4; i++) tick();
        chk("r31_stb_pre", 16'(sel_stb), 16'h0000);
        tick();
        chk("r31_stb", 16'(sel_stb), 16'h0001);
        chk("r31_sel", 16'(sel), 16'(lstepn(16'hACE1, 4) & 16'h007F));
        held = sel;
        for (int i = 6; i <= 12; i++) tick();
        chk("r31_active_guard", 16'(active), 16'h0001);
        tick();
        chk("r31_active_idle", 16'(active), 16'h0000);
        for (int i = 0; i < 5; i++) tick();
        chk("r31_sel_held", 16'(sel), 16'(held));
        chk("r31_stb_idle", 16'(sel_stb), 16'h0000);
        en = 1'b1; interval = 8'd0;
        tick();
        en = 1'b0;
        tick();
        tick();
        chk("r31_restart_stb", 16'(sel_stb), 16'h0001);
        chk("r31_restart_sel", 16'(sel), 16'(lstepn(16'hACE1, 14) & 16'h007F));
        do_reset();

        // Reset in GUARD, also overriding en and seed_load.
        en = 1'b1; interval = 8'd0;
        tick();
        tick();
        tick();
        chk("r32_first_stb", 16'(sel_stb), 16'h0001);
        tick();
        tick();
        rst = 1'b1; seed_load = 1'b1; seed = 16'h0001;
        tick();
        chk("r32_rst_sel", 16'(sel), 16'h0000);
        chk("r32_rst_stb", 16'(sel_stb), 16'h0000);
        chk("r32_rst_active", 16'(active), 16'h0000);
        rst = 1'b0; seed_load = 1'b0;
        tick();
        chk("r32_active_k", 16'(active), 16'h0001);
        tick();
        tick();
        chk("r32_sel_k2", 16'(sel), 16'h0043);
        chk("r32_stb_k2", 16'(sel_stb), 16'h0001);
        for (int i = 3; i <= 11; i++) tick();
        chk("r32_stb_k11", 16'(sel_stb), 16'h0000);
        tick();
        chk("r32_sel_k12", 16'(sel), 16'(lstepn(16'hACE1, 11) & 16'h007F));
        chk("r32_stb_k12", 16'(sel_stb), 16'h0001);
        en = 1'b0;
        do_reset();

        // Reset landing on the UPDATE edge suppresses the strobe.
        en = 1'b1; interval = 8'd0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("r27_stb", 16'(sel_stb), 16'h0000);
        chk("r27_sel", 16'(sel), 16'h0000);
        chk("r27_active", 16'(active), 16'h0000);
        rst = 1'b0; en = 1'b0;
        do_reset();

        // Seed load on the UPDATE edge: old value selected, new seed used afterwards.
        en = 1'b1; interval = 8'd0;
        tick();
        tick();
        seed_load = 1'b1; seed = 16'h1357;
        tick();
        seed_load = 1'b0;
        chk("r33_sel_old", 16'(sel), 16'h0043);
        chk("r33_stb_old", 16'(sel_stb), 16'h0001);
        for (int i = 3; i <= 11; i++) tick();
        tick();
        chk("r33_stb_new", 16'(sel_stb), 16'h0001);
        t = lstepn(16'h1357, 9);
        chk("r33_sel_new", 16'(sel), 16'(t & 16'h007F));
        en = 1'b0;
        do_reset();

        // Continuous run, interval 5: strobe period 15, selects follow the model.
        en = 1'b1; interval = 8'd5;
        tick();
        m = 16'hACE1;
        last_sel = 7'h00;
        for (int c = 1; c <= 60; c++) begin
            tick();
            exp_stb = (c >= 7) && (((c - 7) % 15) == 0);
            if (exp_stb) last_sel = m[6:0];
            m = lstep(m);
            chk($sformatf("r30_stb_c%0d", c), 16'(sel_stb), 16'(exp_stb));
            chk($sformatf("r30_sel_c%0d", c), 16'(sel), 16'(last_sel));
        end
        en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
